aes_round_iter: RTL and testbench
=================================

AES_ROUND_ITER -- requirements
Module: aes_round_iter

Interface
REQ-001 The block SHALL have parameter KEY_BITS, default 128, meaning AES key size; legal values 128/192/256 give round count NR = 10/12/14, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  plaintext block offered.
REQ-005 The block SHALL have port in_ready  output  1  block can accept plaintext this cycle.
REQ-006 The block SHALL have port in_block  input  128  plaintext; bits [127:120] = state byte s0,0, column-major byte order.
REQ-007 The block SHALL have port rk_idx  output  4  round-key index requested this cycle, range 0..NR.
REQ-008 The block SHALL have port rk  input  128  round key for rk_idx, supplied combinationally in the same cycle by the external key store.
REQ-009 The block SHALL have port out_valid  output  1  ciphertext available.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-011 The block SHALL have port out_block  output  128  ciphertext, same byte order as in_block.
REQ-012 The block SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, DONE, plus a 4-bit round counter rnd and a 128-bit state register st.
REQ-014 In IDLE: in_ready=1, rk_idx=0; on in_valid, st <= in_block XOR rk, rnd <= 1, go to RUN.
REQ-015 In RUN: in_ready=0, rk_idx=rnd; each cycle st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk), rnd <= rnd+1.
REQ-016 When rnd==NR in RUN, MixColumns SHALL be omitted (final round), rnd SHALL reset to 0, and the FSM SHALL go to DONE.
REQ-017 In DONE: out_valid=1, out_block=st, rk_idx=0, in_ready=out_ready; out_block SHALL hold stable while out_ready=0.
REQ-018 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE; with out_ready=1 and in_valid=1 it SHALL load in_block XOR rk, set rnd=1, and go to RUN in the same edge.
REQ-019 Latency SHALL be NR+1 rising edges from the input handshake edge to the first cycle with out_valid=1 (11/13/15 for 128/192/256).
REQ-020 Sustained throughput SHALL be one block per NR+1 cycles when out_ready is held high.
REQ-021 in_valid asserted while in RUN SHALL be ignored without loss; the producer holds in_block until in_ready.
REQ-022 out_valid SHALL be registered (derived from the FSM state only); in_ready SHALL depend combinationally only on the FSM state and out_ready.
REQ-023 The round datapath SHALL be combinational between st and its next value, with exactly one register stage (st) per round.

Reset
REQ-024 On rst_n low, asynchronously: FSM=IDLE, rnd=0, st=0, so out_valid=0, out_block=0, busy=0, rk_idx=0, in_ready=1 once released.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the block; no partial ciphertext is ever presented.

Configuration
REQ-026 Macro AES_ROUND_ITER_CNT_EN SHALL, when defined, add output port blk_cnt (32 bits) counting completed output handshakes, wrapping from 0xFFFFFFFF to 0, reset to 0.
REQ-027 Without AES_ROUND_ITER_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 KEY_BITS=128, key 000102..0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 edges after accept.
REQ-029 KEY_BITS=192, key 0001..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 after 13 edges; KEY_BITS=256, key 0001..1f -> 8ea2b7ca516745bfeafc49904b496089 after 15 edges.
REQ-030 Back-to-back: in_valid held high with 3 blocks, out_ready=1 -> 3 correct outputs spaced exactly 11 cycles apart, with no idle cycle between blocks.
REQ-031 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_block stable, in_ready=0; then out_ready=1 -> single handshake, blk_cnt (if enabled) +1.
REQ-032 rst_n pulsed low at round 5 -> outputs 0 immediately, FSM=IDLE; the next block encrypts correctly with no residue from the aborted block.
REQ-033 rk_idx trace for one KEY_BITS=128 block SHALL read 0,1,2,...,10, then 0 in DONE; with AES_ROUND_ITER_CNT_EN, blk_cnt preset near wrap -> 0xFFFFFFFF then 0.

Source files
------------

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES encryptor, one round per clock, external round-key store (rev 1.0).
// Optional AES_ROUND_ITER_CNT_EN adds blk_cnt, a wrapping count of completed output handshakes.
`default_nettype none

module aes_round_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
`ifdef AES_ROUND_ITER_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  localparam logic [3:0] NR = (KEY_BITS == 128) ? 4'd10 :
                              (KEY_BITS == 192) ? 4'd12 : 4'd14;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_iter: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] st, st_nxt;
  logic [127:0] round_out;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of st is state element (row k%4, column k/4), MSB first.
  always_comb begin
    round_out = '0;
    for (int k = 0; k < 16; k++) begin
      sb[k] = SBOX[st[127-8*k -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int k = 0; k < 16; k++) begin
      round_out[127-8*k -: 8] = (rnd == NR) ? sr[k] : mc[k];
    end
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    st_nxt    = st;
    in_ready  = 1'b0;
    rk_idx    = 4'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = in_block ^ rk;
          rnd_nxt   = 4'd1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        rk_idx = rnd;
        st_nxt = round_out ^ rk;
        if (rnd == NR) begin
          rnd_nxt   = 4'd0;
          state_nxt = DONE;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            st_nxt    = in_block ^ rk;
            rnd_nxt   = 4'd1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= 4'd0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      st    <= st_nxt;
    end
  end

  // Intermediate round state never leaves the block; only DONE exposes st.
  assign out_valid = (state == DONE);
  assign out_block = (state == DONE) ? st : '0;
  assign busy      = (state != IDLE);

`ifdef AES_ROUND_ITER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (state == DONE && out_ready) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: three instances (128/192/256-bit keys) against a byte-level AES model.
`default_nettype none

module tb_aes_round_iter;

  int errors = 0;
  int checks = 0;

  logic         clk;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bsy  [3];
  logic [3:0]   ri   [3];
  logic [127:0] ib   [3];
  logic [127:0] ob   [3];
  logic [127:0] rkv  [3];
  logic [127:0] rks  [3][16];
  logic [7:0]   sbt  [256];
`ifdef AES_ROUND_ITER_CNT_EN
  logic [31:0]  cnt  [3];
`endif

  assign rkv[0] = rks[0][ri[0]];
  assign rkv[1] = rks[1][ri[1]];
  assign rkv[2] = rks[2][ri[2]];

  aes_round_iter #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_block(ib[0]),
    .rk_idx(ri[0]), .rk(rkv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_block(ob[0]), .busy(bsy[0])
`ifdef AES_ROUND_ITER_CNT_EN
    , .blk_cnt(cnt[0])
`endif
  );

  aes_round_iter #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_block(ib[1]),
    .rk_idx(ri[1]), .rk(rkv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_block(ob[1]), .busy(bsy[1])
`ifdef AES_ROUND_ITER_CNT_EN
    , .blk_cnt(cnt[1])
`endif
  );

  aes_round_iter #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_block(ib[2]),
    .rk_idx(ri[2]), .rk(rkv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_block(ob[2]), .busy(bsy[2])
`ifdef AES_ROUND_ITER_CNT_EN
    , .blk_cnt(cnt[2])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] y;
    y = {x, x} << n;
    return y[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbt[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // Standard key schedule; key is left-aligned in 256 bits.
  task automatic expand(input int d, input logic [255:0] key, input int kbits);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = kbits / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input int d, input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rks[d][0][127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbt[s[k]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row + 4*col] = t[row + 4*((col + row) % 4)];
      if (r < nr) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*col+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rks[d][r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one block, waits for it, takes it; lat = edges from accept to out_valid, -1 on timeout.
  task automatic run_block(input int d, input logic [127:0] pt, output logic [127:0] got, output int lat);
    int n;
    got = '0;
    lat = -1;
    ib[d] = pt; iv[d] = 1'b1; ordy[d] = 1'b1;
    n = 0;
    while (!ir[d] && n < 100) begin tick(); n++; end
    tick();
    iv[d] = 1'b0;
    n = 1;
    while (!ov[d] && n < 40) begin tick(); n++; end
    if (ov[d]) begin got = ob[d]; lat = n; end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      if (ov[d] !== 1'b0 || ob[d] !== 128'h0) begin
        errors++; $display("FAIL reset_outputs[%0d]: got valid=%b block=%h, expected 0/0", d, ov[d], ob[d]);
      end
      checks++;
      if (bsy[d] !== 1'b0 || ri[d] !== 4'd0) begin
        errors++; $display("FAIL reset_busy_rkidx[%0d]: got busy=%b rk_idx=%0d, expected 0/0", d, bsy[d], ri[d]);
      end
      checks++;
    end
    #7 rst_n = 1'b1;
    tick();
    if (ir[0] !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", ir[0]);
    end
    checks++;
  endtask

  task automatic test_kat();
    logic [127:0] got;
    logic [127:0] exp_ct [3];
    int lat;
    logic [127:0] pt;
    pt = 128'h00112233445566778899aabbccddeeff;
    exp_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 192);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 256);
    for (int d = 0; d < 3; d++) begin
      run_block(d, pt, got, lat);
      if (got !== exp_ct[d]) begin
        errors++; $display("FAIL kat_block[%0d]: got %h expected %h", d, got, exp_ct[d]);
      end
      checks++;
      if (lat != 11 + 2*d) begin
        errors++; $display("FAIL kat_latency[%0d]: got %0d expected %0d", d, lat, 11 + 2*d);
      end
      checks++;
    end
  endtask

  task automatic test_rk_trace();
    logic [127:0] pt;
    pt = rnd128();
    ib[0] = pt; iv[0] = 1'b1; ordy[0] = 1'b1;
    if (ri[0] !== 4'd0 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL trace_idle: got rk_idx=%0d in_ready=%b expected 0/1", ri[0], ir[0]);
    end
    checks++;
    for (int i = 1; i <= 10; i++) begin
      tick();
      iv[0] = 1'b0;
      if (ri[0] !== 4'(i) || ir[0] !== 1'b0 || bsy[0] !== 1'b1 || ov[0] !== 1'b0) begin
        errors++; $display("FAIL trace_run: got rk_idx=%0d ready=%b busy=%b valid=%b expected %0d/0/1/0",
                           ri[0], ir[0], bsy[0], ov[0], i);
      end
      checks++;
    end
    tick();
    if (ri[0] !== 4'd0 || ov[0] !== 1'b1 || ob[0] !== model_enc(0, pt, 10)) begin
      errors++; $display("FAIL trace_done: got rk_idx=%0d valid=%b block=%h expected 0/1/%h",
                         ri[0], ov[0], ob[0], model_enc(0, pt, 10));
    end
    checks++;
    tick();
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++; $display("FAIL trace_idle_after: got valid=%b busy=%b expected 0/0", ov[0], bsy[0]);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [127:0] got;
    logic [127:0] pt;
    logic [255:0] key;
    int lat;
    int d;
    for (int n = 0; n < 9; n++) begin
      d = n % 3;
      key = {rnd128(), rnd128()};
      expand(d, key, 128 + 64*d);
      pt = rnd128();
      run_block(d, pt, got, lat);
      if (got !== model_enc(d, pt, 10 + 2*d) || lat != 11 + 2*d) begin
        errors++; $display("FAIL random[%0d]: got %h lat %0d expected %h lat %0d",
                           n, got, lat, model_enc(d, pt, 10 + 2*d), 11 + 2*d);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts  [3];
    logic [127:0] vals [3];
    int t_out [3];
    int got_n;
    int in_n;
    logic hs_in;
    got_n = 0;
    in_n = 0;
    for (int i = 0; i < 3; i++) begin pts[i] = rnd128(); vals[i] = '0; t_out[i] = 0; end
    ib[0] = pts[0]; iv[0] = 1'b1; ordy[0] = 1'b1;
    for (int cyc = 0; cyc < 80 && got_n < 3; cyc++) begin
      hs_in = iv[0] & ir[0];
      if (ov[0]) begin t_out[got_n] = cyc; vals[got_n] = ob[0]; got_n++; end
      tick();
      if (hs_in) begin
        in_n++;
        if (in_n < 3) ib[0] = pts[in_n];
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    if (got_n != 3) begin
      errors++; $display("FAIL b2b_count: got %0d outputs expected 3", got_n);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (vals[i] !== model_enc(0, pts[i], 10)) begin
        errors++; $display("FAIL b2b_block[%0d]: got %h expected %h", i, vals[i], model_enc(0, pts[i], 10));
      end
      checks++;
    end
    for (int i = 1; i < 3; i++) begin
      if (t_out[i] - t_out[i-1] != 11) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 11", i, t_out[i] - t_out[i-1]);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt;
    logic [127:0] held;
    int n;
`ifdef AES_ROUND_ITER_CNT_EN
    logic [31:0] c0;
`endif
    pt = rnd128();
    ib[0] = pt; iv[0] = 1'b1; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin tick(); n++; end
    held = ob[0];
    if (ov[0] !== 1'b1 || held !== model_enc(0, pt, 10)) begin
      errors++; $display("FAIL bp_first: got valid=%b block=%h expected 1/%h", ov[0], held, model_enc(0, pt, 10));
    end
    checks++;
`ifdef AES_ROUND_ITER_CNT_EN
    c0 = cnt[0];
`endif
    ib[0] = rnd128(); iv[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ov[0] !== 1'b1 || ob[0] !== held || ir[0] !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b block=%h ready=%b expected 1/%h/0",
                           i, ov[0], ob[0], ir[0], held);
      end
      checks++;
      tick();
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    #1;
    if (ir[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", ir[0]);
    end
    checks++;
    tick();
    if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++; $display("FAIL bp_single_handshake: got valid=%b busy=%b expected 0/0", ov[0], bsy[0]);
    end
    checks++;
`ifdef AES_ROUND_ITER_CNT_EN
    if (cnt[0] !== c0 + 32'd1) begin
      errors++; $display("FAIL bp_blk_cnt: got %0d expected %0d", cnt[0], c0 + 32'd1);
    end
    checks++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    logic [127:0] pt;
    int lat;
    ib[0] = rnd128(); iv[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    if (ri[0] !== 4'd5 || bsy[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got rk_idx=%0d busy=%b expected 5/1", ri[0], bsy[0]);
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if (ov[0] !== 1'b0 || ob[0] !== 128'h0 || bsy[0] !== 1'b0 || ri[0] !== 4'd0) begin
      errors++; $display("FAIL midrst_outputs: got valid=%b block=%h busy=%b rk_idx=%0d expected 0/0/0/0",
                         ov[0], ob[0], bsy[0], ri[0]);
    end
    checks++;
    #2 rst_n = 1'b1;
    tick();
    pt = rnd128();
    run_block(0, pt, got, lat);
    if (got !== model_enc(0, pt, 10) || lat != 11) begin
      errors++; $display("FAIL midrst_next: got %h lat %0d expected %h lat 11", got, lat, model_enc(0, pt, 10));
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; ib[d] = '0;
      for (int r = 0; r < 16; r++) rks[d][r] = '0;
    end
    build_sbox();
    #23;
    test_reset();
    test_kat();
    test_rk_trace();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
